// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the parametrised UART receiver:
//   - rx_state_e   : receive FSM states
//   - PAR_EVEN/ODD : encodings of the PAR_TYP input
//   - PRESCALE_MIN : smallest oversampling ratio honoured (smaller values are
//                    latched as this one)
//   - maj3         : 2-of-3 majority helper used by the optional sample voter
// Optional feature macro used by the receiver files: UART_RX_MAJORITY_EN.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;
    localparam int   PRESCALE_MIN = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit edge counter and sample-point generator for uart_rx_param.
// The counter runs 0..prescale-1 for every bit while 'run' is high and is
// forced to 0 by 'start' (start edge seen in IDLE). The sample point is
// S = prescale/2.
// Build option UART_RX_MAJORITY_EN: bit_val is the 2-of-3 vote of the line at
// S-1, S and S+1; otherwise it is the single sample at S. The strobe timing is
// the same in both builds.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               clear counter (first cycle of a frame follows)
//   run                 FSM is inside a frame
//   prescale            latched clk cycles per bit (>= 4)
//   rx_late / rx_early  line one cycle before / after rx_mid (majority build)
//   rx_mid              synchronised line
//   sample_stb          counter == S
//   bit_end             counter == prescale-1
//   bit_val             sampled bit value, valid with sample_stb
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
`ifdef UART_RX_MAJORITY_EN
    input  logic                  rx_late,
    input  logic                  rx_early,
`endif
    input  logic                  rx_mid,
    output logic                  sample_stb,
    output logic                  bit_end,
    output logic                  bit_val
);

    localparam logic [PRESCALE_W-1:0] CNT_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] CNT_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] cnt_r;
    logic [PRESCALE_W-1:0] mid_s;
    logic [PRESCALE_W-1:0] last_s;

    // Sample point and last count of the current bit.
    always_comb begin
        mid_s  = {1'b0, prescale[PRESCALE_W-1:1]};
        last_s = prescale - CNT_ONE;
    end

    // Edge counter: restarts on the start edge, wraps at the end of every bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (start) begin
            cnt_r <= CNT_ZERO;
        end else if (!run) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r == last_s) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Strobes and bit decision. In the majority build rx_early already holds
    // the value rx_mid will show one cycle later, so the vote over S-1..S+1 is
    // available at S without moving the strobe.
    always_comb begin
        sample_stb = run && (cnt_r == mid_s);
        bit_end    = run && (cnt_r == last_s);
`ifdef UART_RX_MAJORITY_EN
        bit_val    = maj3(rx_late, rx_mid, rx_early);
`else
        bit_val    = rx_mid;
`endif
    end

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: DATA_W data bits (5..9, LSB first), optional
// even/odd parity, one or two stop bits, valid/ready output with overrun
// detection. Frame settings are latched at the start edge.
// Build option UART_RX_MAJORITY_EN enables 3-sample majority voting per bit.
// Ports:
//   clk, rst                 clock, async active-low reset
//   RX_IN                    serial line (idle high, asynchronous)
//   PAR_EN, PAR_TYP, STOP2   frame format (PAR_TYP 0 even / 1 odd)
//   Prescale                 clk cycles per bit (values below 4 act as 4)
//   data_ready               consumer accepts P_DATA
//   P_DATA, data_valid       received word and its valid flag
//   par_error, stop_error    one-cycle pulses for a discarded bad frame
//   overrun_error            one-cycle pulse when a good frame is dropped
//   busy                     receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  data_ready,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    output logic                  par_error,
    output logic                  stop_error,
    output logic                  overrun_error,
    output logic                  busy
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_MIN_V = PRESCALE_W'(PRESCALE_MIN);
    localparam logic [3:0]            BIT_LAST       = 4'(DATA_W - 1);
    localparam logic [3:0]            BIT_ONE        = 4'd1;

    // Line synchroniser; rx_prev_r is one cycle older for edge detection.
    logic rx_meta_r, rx_sync_r, rx_prev_r;

    rx_state_e             state_r, state_s;
    logic [3:0]            bit_cnt_r, bit_cnt_s;
    logic [DATA_W-1:0]     shift_r, shift_s;
    logic                  par_bad_r, par_bad_s;
    logic                  stop_bad_r, stop_bad_s;

    logic                  par_en_r, par_typ_r, stop2_r;
    logic [PRESCALE_W-1:0] prescale_r;

    logic start_edge_s, sample_stb_s, bit_end_s, bit_val_s;
    logic frame_done_s, frame_err_s, load_s, drop_s, xfer_s, valid_s;

    logic [DATA_W-1:0] p_data_r;
    logic data_valid_r, par_error_r, stop_error_r, overrun_error_r, busy_r;

    // Two-flop synchroniser plus edge-detect history, reset to idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= RX_IN;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Start edge detection: only meaningful while idle.
    always_comb begin
        start_edge_s = (state_r == ST_IDLE) && rx_prev_r && !rx_sync_r;
    end

    // Frame settings captured at the start edge, held for the whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            stop2_r    <= 1'b0;
            prescale_r <= PRESCALE_MIN_V;
        end else if (start_edge_s) begin
            par_en_r   <= PAR_EN;
            par_typ_r  <= PAR_TYP;
            stop2_r    <= STOP2;
            prescale_r <= (Prescale < PRESCALE_MIN_V) ? PRESCALE_MIN_V : Prescale;
        end else begin
            par_en_r   <= par_en_r;
            par_typ_r  <= par_typ_r;
            stop2_r    <= stop2_r;
            prescale_r <= prescale_r;
        end
    end

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst),
        .start      (start_edge_s),
        .run        (state_r != ST_IDLE),
        .prescale   (prescale_r),
`ifdef UART_RX_MAJORITY_EN
        .rx_late    (rx_prev_r),
        .rx_early   (rx_meta_r),
`endif
        .rx_mid     (rx_sync_r),
        .sample_stb (sample_stb_s),
        .bit_end    (bit_end_s),
        .bit_val    (bit_val_s)
    );

    // FSM state, bit counter, shift register and error accumulators.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= {DATA_W{1'b0}};
            par_bad_r  <= 1'b0;
            stop_bad_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            par_bad_r  <= par_bad_s;
            stop_bad_r <= stop_bad_s;
        end
    end

    // FSM next state. Bit transitions happen at bit_end; decisions at the
    // sample strobe. The frame completes at the sample point of the last
    // stop bit so the line can start the next frame right away.
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        par_bad_s    = par_bad_r;
        stop_bad_s   = stop_bad_r;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_s    = ST_START;
                    bit_cnt_s  = 4'd0;
                    par_bad_s  = 1'b0;
                    stop_bad_s = 1'b0;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_stb_s && bit_val_s) begin
                    state_s = ST_IDLE;          // false start, silently dropped
                end else if (bit_end_s) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = 4'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_stb_s) begin
                    shift_s = {bit_val_s, shift_r[DATA_W-1:1]};
                end else begin
                    shift_s = shift_r;
                end
                if (bit_end_s && (bit_cnt_r == BIT_LAST)) begin
                    state_s   = par_en_r ? ST_PARITY : ST_STOP;
                    bit_cnt_s = 4'd0;
                end else if (bit_end_s) begin
                    bit_cnt_s = bit_cnt_r + BIT_ONE;
                end else begin
                    bit_cnt_s = bit_cnt_r;
                end
            end
            ST_PARITY: begin
                if (sample_stb_s) begin
                    // Expected bit is ^data for even, its inverse for odd.
                    par_bad_s = bit_val_s ^ (^shift_r) ^ (par_typ_r == PAR_ODD);
                end else begin
                    par_bad_s = par_bad_r;
                end
                if (bit_end_s) begin
                    state_s   = ST_STOP;
                    bit_cnt_s = 4'd0;
                end else begin
                    state_s   = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (sample_stb_s) begin
                    stop_bad_s = stop_bad_r | ~bit_val_s;
                    if (bit_cnt_r == (stop2_r ? 4'd1 : 4'd0)) begin
                        frame_done_s = 1'b1;
                        state_s      = ST_IDLE;
                    end else begin
                        state_s      = ST_STOP;
                    end
                end else if (bit_end_s) begin
                    bit_cnt_s = bit_cnt_r + BIT_ONE;
                end else begin
                    bit_cnt_s = bit_cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output-stage decisions: a new load beats a same-cycle transfer clear.
    always_comb begin
        frame_err_s = par_bad_r | stop_bad_s;
        xfer_s      = data_valid_r && data_ready;
        load_s      = frame_done_s && !frame_err_s && (!data_valid_r || data_ready);
        drop_s      = frame_done_s && !frame_err_s && data_valid_r && !data_ready;
        if (load_s) begin
            valid_s = 1'b1;
        end else if (xfer_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = data_valid_r;
        end
    end

    // Registered outputs; error flags are single-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_data_r        <= {DATA_W{1'b0}};
            data_valid_r    <= 1'b0;
            par_error_r     <= 1'b0;
            stop_error_r    <= 1'b0;
            overrun_error_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            p_data_r        <= load_s ? shift_r : p_data_r;
            data_valid_r    <= valid_s;
            par_error_r     <= frame_done_s && par_bad_r;
            stop_error_r    <= frame_done_s && stop_bad_s;
            overrun_error_r <= drop_s;
            busy_r          <= (state_s != ST_IDLE);
        end
    end

    assign P_DATA        = p_data_r;
    assign data_valid    = data_valid_r;
    assign par_error     = par_error_r;
    assign stop_error    = stop_error_r;
    assign overrun_error = overrun_error_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Directed bench for uart_rx_param: an 8-bit and a 7-bit instance share the
// clock, reset and frame-format inputs; each has its own serial line.
// A negedge monitor counts output pulses and captures transferred words.
// With UART_RX_MAJORITY_EN defined an extra glitch-rejection test runs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
    logic [5:0] prescale = 6'd16;
    logic       rdy = 1'b1;
    logic       tx_bit = 1'b1, tx_sel = 1'b0;
    logic       rx8, rx7;

    logic [7:0] pd8;
    logic       dv8, perr8, serr8, ovr8, busy8;
    logic [6:0] pd7;
    logic       dv7, perr7, serr7, ovr7, busy7;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;

    // monitor state
    logic       dv8_q = 1'b0, dv7_q = 1'b0;
    int         dv8_rises = 0, dv7_rises = 0, dv8_rise_cyc = 0;
    logic [7:0] xfer8_data = 8'h00;
    logic [6:0] xfer7_data = 7'h00;
    int         perr8_cnt = 0, serr8_cnt = 0, ovr8_cnt = 0, busy8_cyc = 0;
    int         perr7_cnt = 0, serr7_cnt = 0;

    assign rx8 = tx_sel ? 1'b1 : tx_bit;
    assign rx7 = tx_sel ? tx_bit : 1'b1;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_W(8), .PRESCALE_W(6)) dut8 (
        .clk(clk), .rst(rst), .RX_IN(rx8), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .Prescale(prescale), .data_ready(rdy), .P_DATA(pd8),
        .data_valid(dv8), .par_error(perr8), .stop_error(serr8),
        .overrun_error(ovr8), .busy(busy8)
    );

    uart_rx_param #(.DATA_W(7), .PRESCALE_W(6)) dut7 (
        .clk(clk), .rst(rst), .RX_IN(rx7), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .Prescale(prescale), .data_ready(rdy), .P_DATA(pd7),
        .data_valid(dv7), .par_error(perr7), .stop_error(serr7),
        .overrun_error(ovr7), .busy(busy7)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        dv8_q <= dv8;
        dv7_q <= dv7;
        if (dv8 && !dv8_q) begin
            dv8_rises    <= dv8_rises + 1;
            dv8_rise_cyc <= cyc;
        end
        if (dv7 && !dv7_q) dv7_rises <= dv7_rises + 1;
        if (dv8 && rdy) xfer8_data <= pd8;
        if (dv7 && rdy) xfer7_data <= pd7;
        if (perr8) perr8_cnt <= perr8_cnt + 1;
        if (serr8) serr8_cnt <= serr8_cnt + 1;
        if (ovr8)  ovr8_cnt  <= ovr8_cnt + 1;
        if (busy8) busy8_cyc <= busy8_cyc + 1;
        if (perr7) perr7_cnt <= perr7_cnt + 1;
        if (serr7) serr7_cnt <= serr7_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame using the current par_en/par_typ/stop2 settings.
    task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                              input int p, input bit par_flip, input bit stop2_low,
                              input int glitch_bit);
        logic bits [0:13];
        int   nb;
        logic par;
        tx_sel = sel;
        nb = 0;
        bits[nb] = 1'b0;
        nb = nb + 1;
        par = par_typ;
        for (int i = 0; i < nbits; i++) begin
            bits[nb] = data[i];
            par = par ^ data[i];
            nb = nb + 1;
        end
        if (par_en) begin
            bits[nb] = par ^ par_flip;
            nb = nb + 1;
        end
        bits[nb] = 1'b1;
        nb = nb + 1;
        if (stop2) begin
            bits[nb] = ~stop2_low;
            nb = nb + 1;
        end
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < p; j++) begin
                @(negedge clk);
                if (b == 0 && j == 0) t_start = cyc;
                tx_bit = (b == glitch_bit && j == p / 2 + 1) ? ~bits[b] : bits[b];
            end
        end
        @(negedge clk);
        tx_bit = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle(3);
        n_checks++;
        if (pd8 !== 8'h00) begin n_fail++; $display("FAIL reset_pdata got %h want 00", pd8); end
        n_checks++;
        if ({dv8, busy8, perr8, serr8, ovr8} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_flags got %b want 00000", {dv8, busy8, perr8, serr8, ovr8});
        end
        rst = 1'b1;
        idle(5);
    endtask

    task automatic test_basic;
        int r0, pe0, se0;
        r0 = dv8_rises; pe0 = perr8_cnt; se0 = serr8_cnt;
        par_en = 1'b0; stop2 = 1'b0; prescale = 6'd32; rdy = 1'b1;
        send_frame(1'b0, 9'h045, 8, 32, 1'b0, 1'b0, -1);
        idle(4);
        n_checks++;
        if (dv8_rises !== r0 + 1) begin n_fail++; $display("FAIL basic_valid_count got %0d want %0d", dv8_rises - r0, 1); end
        n_checks++;
        if (xfer8_data !== 8'h45) begin n_fail++; $display("FAIL basic_data got %h want 45", xfer8_data); end
        // start sampled one cycle before the first capture edge: 3+9*32+16 +1
        n_checks++;
        if (dv8_rise_cyc - t_start !== 308) begin
            n_fail++; $display("FAIL basic_latency got %0d want 308", dv8_rise_cyc - t_start);
        end
        n_checks++;
        if (perr8_cnt !== pe0 || serr8_cnt !== se0) begin
            n_fail++; $display("FAIL basic_flags got %0d/%0d want 0/0", perr8_cnt - pe0, serr8_cnt - se0);
        end
    endtask

    task automatic test_parity;
        int r0, pe0, se0;
        par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1; prescale = 6'd16;
        pe0 = perr8_cnt;
        send_frame(1'b0, 9'h0AA, 8, 16, 1'b0, 1'b0, -1);
        idle(4);
        n_checks++;
        if (xfer8_data !== 8'hAA || perr8_cnt !== pe0) begin
            n_fail++; $display("FAIL parity_good got %h/%0d want aa/0", xfer8_data, perr8_cnt - pe0);
        end
        r0 = dv8_rises; pe0 = perr8_cnt; se0 = serr8_cnt;
        send_frame(1'b0, 9'h0AA, 8, 16, 1'b1, 1'b0, -1);
        idle(4);
        n_checks++;
        if (perr8_cnt !== pe0 + 1) begin n_fail++; $display("FAIL parity_err_pulse got %0d want 1", perr8_cnt - pe0); end
        n_checks++;
        if (dv8_rises !== r0 || dv8 !== 1'b0) begin
            n_fail++; $display("FAIL parity_no_valid got %0d/%b want 0/0", dv8_rises - r0, dv8);
        end
        n_checks++;
        if (serr8_cnt !== se0) begin n_fail++; $display("FAIL parity_no_stop got %0d want 0", serr8_cnt - se0); end
    endtask

    task automatic test_stop7;
        int r0, pe0, se0;
        par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1; prescale = 6'd8;
        send_frame(1'b1, 9'h05A, 7, 8, 1'b0, 1'b0, -1);
        idle(4);
        n_checks++;
        if (xfer7_data !== 7'h5A) begin n_fail++; $display("FAIL w7_good_data got %h want 5a", xfer7_data); end
        r0 = dv7_rises; pe0 = perr7_cnt; se0 = serr7_cnt;
        send_frame(1'b1, 9'h05A, 7, 8, 1'b0, 1'b1, -1);
        idle(4);
        n_checks++;
        if (serr7_cnt !== se0 + 1) begin n_fail++; $display("FAIL w7_stop_err got %0d want 1", serr7_cnt - se0); end
        n_checks++;
        if (dv7_rises !== r0 || perr7_cnt !== pe0) begin
            n_fail++; $display("FAIL w7_no_valid got %0d/%0d want 0/0", dv7_rises - r0, perr7_cnt - pe0);
        end
        tx_sel = 1'b0;
    endtask

    task automatic test_overrun;
        int o0;
        par_en = 1'b0; stop2 = 1'b0; prescale = 6'd16;
        rdy = 1'b0;
        o0 = ovr8_cnt;
        send_frame(1'b0, 9'h011, 8, 16, 1'b0, 1'b0, -1);
        idle(4);
        n_checks++;
        if (pd8 !== 8'h11 || dv8 !== 1'b1) begin
            n_fail++; $display("FAIL ovr_first got %h/%b want 11/1", pd8, dv8);
        end
        send_frame(1'b0, 9'h022, 8, 16, 1'b0, 1'b0, -1);
        idle(4);
        n_checks++;
        if (ovr8_cnt !== o0 + 1) begin n_fail++; $display("FAIL ovr_pulse got %0d want 1", ovr8_cnt - o0); end
        n_checks++;
        if (pd8 !== 8'h11 || dv8 !== 1'b1) begin
            n_fail++; $display("FAIL ovr_held got %h/%b want 11/1", pd8, dv8);
        end
        @(posedge clk);
        #1 rdy = 1'b1;
        idle(2);
        n_checks++;
        if (dv8 !== 1'b0 || xfer8_data !== 8'h11) begin
            n_fail++; $display("FAIL ovr_release got %b/%h want 0/11", dv8, xfer8_data);
        end
    endtask

    task automatic test_glitch;
        int r0, b0, pe0, se0;
        prescale = 6'd16;
        r0 = dv8_rises; b0 = busy8_cyc; pe0 = perr8_cnt; se0 = serr8_cnt;
        @(negedge clk);
        tx_bit = 1'b0;
        idle(4);
        tx_bit = 1'b1;
        idle(24);
        n_checks++;
        if (busy8_cyc - b0 < 1 || busy8_cyc - b0 > 16) begin
            n_fail++; $display("FAIL glitch_busy_len got %0d want 1..16", busy8_cyc - b0);
        end
        n_checks++;
        if (busy8 !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end got %b want 0", busy8); end
        n_checks++;
        if (dv8_rises !== r0 || perr8_cnt !== pe0 || serr8_cnt !== se0) begin
            n_fail++; $display("FAIL glitch_quiet got %0d/%0d/%0d want 0/0/0",
                                dv8_rises - r0, perr8_cnt - pe0, serr8_cnt - se0);
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority;
        prescale = 6'd16;
        send_frame(1'b0, 9'h00F, 8, 16, 1'b0, 1'b0, 1);
        idle(4);
        n_checks++;
        if (xfer8_data !== 8'h0F) begin n_fail++; $display("FAIL majority_data got %h want 0f", xfer8_data); end
    endtask
`endif

    task automatic test_min_prescale;
        prescale = 6'd1;     // acts as 4 cycles per bit
        send_frame(1'b0, 9'h096, 8, 4, 1'b0, 1'b0, -1);
        idle(4);
        n_checks++;
        if (xfer8_data !== 8'h96) begin n_fail++; $display("FAIL minpre_data got %h want 96", xfer8_data); end
    endtask

    task automatic test_reset_mid;
        int r0, pe0, se0;
        prescale = 6'd16; tx_sel = 1'b0;
        // start, bit0=1, bit1=0, bit2=0, half of bit3=0 of 0x81
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            tx_bit = (c / 16 == 1) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        tx_bit = 1'b1;
        idle(2);
        n_checks++;
        if (pd8 !== 8'h00 || dv8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs got %h/%b/%b want 00/0/0", pd8, dv8, busy8);
        end
        idle(40);
        rst = 1'b1;
        idle(20);
        r0 = dv8_rises; pe0 = perr8_cnt; se0 = serr8_cnt;
        send_frame(1'b0, 9'h03C, 8, 16, 1'b0, 1'b0, -1);
        idle(4);
        n_checks++;
        if (xfer8_data !== 8'h3C || dv8_rises !== r0 + 1) begin
            n_fail++; $display("FAIL midrst_data got %h/%0d want 3c/1", xfer8_data, dv8_rises - r0);
        end
        n_checks++;
        if (perr8_cnt !== pe0 || serr8_cnt !== se0) begin
            n_fail++; $display("FAIL midrst_flags got %0d/%0d want 0/0", perr8_cnt - pe0, serr8_cnt - se0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop7();
        test_overrun();
        test_glitch();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        test_min_prescale();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
